// File: rtl/avalon_triangle_master_pkg.sv
// Shared types and constants for the triangle-test Avalon-MM master.
package avalon_triangle_master_pkg;

    // IDLE wait cmd | WR_A/B/C write sides | RD read verdict | RD_WAIT readdata latency | DONE result pulse
    typedef enum logic [2:0] {
        IDLE,
        WR_A,
        WR_B,
        WR_C,
        RD,
        RD_WAIT,
        DONE
    } state_t;

    localparam logic [1:0] ADDR_A      = 2'd0;
    localparam logic [1:0] ADDR_B      = 2'd1;
    localparam logic [1:0] ADDR_C      = 2'd2;
    localparam logic [1:0] ADDR_RESULT = 2'd3;

    localparam int TMO_CNT_W = 16;

endpackage

// File: rtl/avalon_triangle_master_if.sv
// Command, result and Avalon-MM signals between host, master and triangle slave.
interface avalon_triangle_master_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] side_a;
    logic [31:0] side_b;
    logic [31:0] side_c;
    logic        result_valid;
    logic        result_is_triangle;
    logic [31:0] result_raw;
    logic        result_error;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic        waitrequest;
    logic [31:0] readdata;

    modport master (
        input  cmd_valid, side_a, side_b, side_c, waitrequest, readdata,
        output cmd_ready, result_valid, result_is_triangle, result_raw, result_error,
        output address, read, write, writedata
    );

    modport slave (
        output cmd_valid, side_a, side_b, side_c, waitrequest, readdata,
        input  cmd_ready, result_valid, result_is_triangle, result_raw, result_error,
        input  address, read, write, writedata
    );

endinterface

// File: rtl/avalon_xfer_timeout.sv
// Saturating waitrequest-stall counter; expired fires on the stall edge that reaches the limit.
module avalon_xfer_timeout
    import avalon_triangle_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic stall,
    input  logic clear,
    output logic expired
);

    localparam logic [TMO_CNT_W:0] LIMIT = TIMEOUT_CYCLES[TMO_CNT_W:0];

    logic [TMO_CNT_W-1:0] count;
    logic [TMO_CNT_W:0]   count_inc;

    assign count_inc = {1'b0, count} + {{TMO_CNT_W{1'b0}}, 1'b1};
    assign expired   = (LIMIT != '0) && stall && (count_inc >= LIMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (stall && (count != '1)) begin
            count <= count_inc[TMO_CNT_W-1:0];
        end
    end

endmodule

// File: rtl/avalon_triangle_master.sv
// Writes three sides to the triangle slave, reads back the verdict from address 3
// and reports it, aborting with an error if any transfer stalls past the timeout.
module avalon_triangle_master
    import avalon_triangle_master_pkg::*;
#(
    parameter int READ_CAPTURE_DELAY = 1,
    parameter int TIMEOUT_CYCLES     = 255
) (
    input  logic                            clk,
    input  logic                            reset,
    avalon_triangle_master_if.master        bus
);

    localparam logic [1:0] DLY_LAST = 2'(READ_CAPTURE_DELAY - 1);

    state_t      state;
    logic [31:0] lat_b;
    logic [31:0] lat_c;
    logic [1:0]  dly_cnt;
    logic        in_xfer;
    logic        stall;
    logic        xfer_clr;
    logic        tmo;

    assign in_xfer  = (state == WR_A) || (state == WR_B) || (state == WR_C) || (state == RD);
    assign stall    = in_xfer && bus.waitrequest;
    assign xfer_clr = !in_xfer || !bus.waitrequest;

    avalon_xfer_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .stall   (stall),
        .clear   (xfer_clr),
        .expired (tmo)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                  <= IDLE;
            lat_b                  <= '0;
            lat_c                  <= '0;
            dly_cnt                <= '0;
            bus.cmd_ready          <= 1'b1;
            bus.read               <= 1'b0;
            bus.write              <= 1'b0;
            bus.address            <= ADDR_A;
            bus.writedata          <= '0;
            bus.result_valid       <= 1'b0;
            bus.result_is_triangle <= 1'b0;
            bus.result_raw         <= '0;
            bus.result_error       <= 1'b0;
        end else begin
            bus.result_valid <= 1'b0;
            if (in_xfer && tmo) begin
                bus.read               <= 1'b0;
                bus.write              <= 1'b0;
                bus.result_valid       <= 1'b1;
                bus.result_is_triangle <= 1'b0;
                bus.result_raw         <= '0;
                bus.result_error       <= 1'b1;
                state                  <= DONE;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.cmd_valid) begin
                            lat_b         <= bus.side_b;
                            lat_c         <= bus.side_c;
                            bus.cmd_ready <= 1'b0;
                            bus.write     <= 1'b1;
                            bus.address   <= ADDR_A;
                            bus.writedata <= bus.side_a;
                            state         <= WR_A;
                        end
                    end
                    WR_A: begin
                        if (!bus.waitrequest) begin
                            bus.address   <= ADDR_B;
                            bus.writedata <= lat_b;
                            state         <= WR_B;
                        end
                    end
                    WR_B: begin
                        if (!bus.waitrequest) begin
                            bus.address   <= ADDR_C;
                            bus.writedata <= lat_c;
                            state         <= WR_C;
                        end
                    end
                    WR_C: begin
                        if (!bus.waitrequest) begin
                            bus.write   <= 1'b0;
                            bus.read    <= 1'b1;
                            bus.address <= ADDR_RESULT;
                            state       <= RD;
                        end
                    end
                    RD: begin
                        if (!bus.waitrequest) begin
                            bus.read <= 1'b0;
                            if (READ_CAPTURE_DELAY == 0) begin
                                bus.result_valid       <= 1'b1;
                                bus.result_is_triangle <= bus.readdata[0];
                                bus.result_raw         <= bus.readdata;
                                bus.result_error       <= 1'b0;
                                state                  <= DONE;
                            end else begin
                                dly_cnt <= DLY_LAST;
                                state   <= RD_WAIT;
                            end
                        end
                    end
                    RD_WAIT: begin
                        if (dly_cnt == 2'd0) begin
                            bus.result_valid       <= 1'b1;
                            bus.result_is_triangle <= bus.readdata[0];
                            bus.result_raw         <= bus.readdata;
                            bus.result_error       <= 1'b0;
                            state                  <= DONE;
                        end else begin
                            dly_cnt <= dly_cnt - 2'd1;
                        end
                    end
                    DONE: begin
                        bus.cmd_ready <= 1'b1;
                        state         <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
